fact_sched: RTL
===============

FACT_SCHED -- requirements
Module: fact_sched

Interface
REQ-001 Parameter: MAXN, 20, largest operand whose factorial fits in 64 bits; larger operands report overflow.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester request level; bit i = requester i; held until its ack.
REQ-005 Port: n_in  input  128  operands; requester i at bits [32i+31:32i], unsigned, stable while req[i] high.
REQ-006 Port: ack  output  4  one-hot, registered, one-cycle pulse; operand of that requester captured.
REQ-007 Port: busy  output  1  high whenever state is not IDLE.
REQ-008 Port: out_valid  output  1  registered one-cycle pulse; Out, out_id and ovf valid.
REQ-009 Port: out_id  output  2  index of requester that owns the current result.
REQ-010 Port: Out  output  64  factorial result; holds until next out_valid.
REQ-011 Port: ovf  output  1  result-overflow flag qualified by out_valid; holds with Out.

Function
REQ-012 FSM states: IDLE, CALC, DONE; the block owns one iterative 64x32 multiply datapath (accumulator a[63:0], counter b[31:0]) shared by all requesters.
REQ-013 IDLE, req==0: stay IDLE; no outputs change.
REQ-014 IDLE, req!=0: grant by round-robin from ptr+1 upward modulo 4 (ptr = last granted index); that edge sets ack bit, ptr, out_id-pending, a=1, b=n_in of winner, state=CALC.
REQ-015 Grant edge with winner operand > MAXN: state=DONE directly with Out=0, ovf=1; no multiply performed.
REQ-016 CALC, b>1: a <= a*b (low 64 bits), b <= b-1, stay CALC.
REQ-017 CALC, b<=1: Out <= a, ovf <= 0, out_id <= granted index, out_valid <= 1, state=DONE.
REQ-018 DONE: out_valid and ack low after next edge; state=IDLE; requests not sampled in DONE.
REQ-019 Latency: out_valid rises max(N,1) cycles after ack rises for N<=MAXN; 1 cycle for N>MAXN.
REQ-020 0! = 1! = 1.
REQ-021 ack asserted only for the edge after grant; all other cycles ack=0.
REQ-022 Requester deasserts req in the cycle its ack is high; req still high at the next IDLE sample is a new request.
REQ-023 Requests arriving during CALC/DONE wait; no request is dropped while held.
REQ-024 Only one operation in flight; operand changes after ack have no effect.
REQ-025 Round-robin is fair: with all four req held, grants cycle 0,1,2,3,0,...

Reset
REQ-026 rst low forces immediately: state=IDLE, ptr=3 (requester 0 first), a=0, b=0, Out=0, ovf=0, out_id=0, out_valid=0, ack=0, busy=0.
REQ-027 Reset mid-CALC aborts the operation; no out_valid is produced for it after release.
REQ-028 First grant evaluated on the first rising edge with rst high.

Verification
REQ-029 req=0001, n0=5 -> ack=0001 one cycle; out_valid 5 cycles later; Out=120, out_id=0, ovf=0.
REQ-030 req=0010, n1=0 then separately n1=1 -> Out=1 each, out_valid 1 cycle after ack.
REQ-031 req=0100, n2=20 -> Out=2432902008176640000, ovf=0; n2=21 -> Out=0, ovf=1, 1-cycle latency.
REQ-032 req=1111 held continuously, n=3,4,2,6 -> grant order 0,1,2,3,0; results 6,24,2,720 with matching out_id.
REQ-033 req=0001, n0=10, rst pulsed low 4 cycles after ack -> all outputs 0 immediately, no out_valid after release; next request from 0 returns 3628800.
REQ-034 req=0001 during CALC of requester 2 -> ack to 0 only after requester 2's DONE; both results correct.

Source files
------------

// File: rtl/fact_sched.sv
// Round-robin scheduler that shares one iterative 64x32 factorial datapath
// among four requesters; results are tagged with the owning requester index.
module fact_sched #(
  parameter int unsigned MAXN = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] n_in,
  output logic [3:0]   ack,
  output logic         busy,
  output logic         out_valid,
  output logic [1:0]   out_id,
  output logic [63:0]  Out,
  output logic         ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [1:0]  ptr_reg;
  logic [1:0]  gid_reg;
  logic [63:0] a_reg;
  logic [31:0] b_reg;
  logic        ovf_pend_reg;

  logic [31:0] opnd [4];
  logic [1:0]  win;
  logic [1:0]  idx;
  logic [31:0] win_n;
  logic [63:0] prod;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_opnd
      assign opnd[gi] = n_in[32*gi +: 32];
    end
  endgenerate

  // Scan from the farthest candidate to the nearest so the requester
  // closest to ptr+1 overrides the others.
  always_comb begin
    win = ptr_reg;
    idx = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr_reg + k[1:0];
      if (req[idx]) win = idx;
    end
  end

  assign win_n = opnd[win];
  assign prod  = a_reg * {32'd0, b_reg};
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd3;
      gid_reg      <= 2'd0;
      a_reg        <= 64'd0;
      b_reg        <= 32'd0;
      ovf_pend_reg <= 1'b0;
      ack          <= 4'd0;
      out_valid    <= 1'b0;
      out_id       <= 2'd0;
      Out          <= 64'd0;
      ovf          <= 1'b0;
    end else begin
      ack       <= 4'd0;
      out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            ack     <= 4'b0001 << win;
            ptr_reg <= win;
            gid_reg <= win;
            a_reg   <= 64'd1;
            b_reg   <= win_n;
            if (win_n > MAXN) begin
              // Result is known without multiplying; publish it one cycle later.
              state_reg    <= DONE;
              Out          <= 64'd0;
              ovf          <= 1'b1;
              out_id       <= win;
              ovf_pend_reg <= 1'b1;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (b_reg > 32'd1) begin
            a_reg <= prod;
            b_reg <= b_reg - 32'd1;
          end else begin
            Out       <= a_reg;
            ovf       <= 1'b0;
            out_id    <= gid_reg;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          out_valid    <= ovf_pend_reg;
          ovf_pend_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
